// File: rtl/pattern_detect_pkg.sv
// rtl/pattern_detect_pkg.sv - shared state sizing, S_0 encoding and transition-table builder
package pattern_detect_pkg;

  localparam int S_0 = 0;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Next state from S_k on bit b: longest suffix of (k-bit prefix, b) that is a pattern prefix.
  // k == pat_w is S_MATCH; the suffix length is capped at pat_w so this stays proper there.
  function automatic int fallback(input logic [15:0] pat, input int pat_w, input int k,
                                  input logic b);
    int best;
    best = 0;
    for (int l = 1; l <= pat_w; l++) begin
      if (l <= k + 1) begin
        logic ok;
        ok = 1'b1;
        for (int m = 0; m < l; m++) begin
          int j;
          logic sb;
          j = k + 1 - l + m;
          if (j == k) sb = b;
          else sb = pat[pat_w - 1 - j];
          if (sb != pat[pat_w - 1 - m]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/pattern_detect_if.sv
// rtl/pattern_detect_if.sv - serial input, counter clear and detector status bundle
interface pattern_detect_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic                         in_valid;
  logic                         in;
  logic                         cnt_clr;
  logic                         match;
  logic [$clog2(PAT_W+1)-1:0]   progress;
  logic [CNT_W-1:0]             match_cnt;

  modport master (output in_valid, in, cnt_clr, input match, progress, match_cnt);
  modport slave  (input in_valid, in, cnt_clr, output match, progress, match_cnt);
endinterface

// File: rtl/pattern_detect_cnt.sv
// rtl/pattern_detect_cnt.sv - saturating match counter with clear priority over increment
module pattern_detect_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pattern_detect_fsm.sv
// rtl/pattern_detect_fsm.sv - serial pattern detector FSM; PATTERN_DETECT_CNT_EN adds the match counter
module pattern_detect_fsm
  import pattern_detect_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  pattern_detect_if.slave  bus
);

  localparam int SW = state_w(PAT_W);
  localparam int NS = 1 << SW;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

  logic [SW-1:0] state, state_nxt;
  logic [SW-1:0] nxt_tab [NS][2];
  logic [SW-1:0] prog_tab [NS];
  logic          enter_match;

  // Unreachable encodings reuse the S_0 row, and without overlap S_MATCH does too.
  for (genvar s = 0; s < NS; s++) begin : g_row
    localparam int K = (s > PAT_W || (s == PAT_W && !OVERLAP)) ? S_0 : s;
    assign prog_tab[s] = SW'((s > PAT_W) ? S_0 : s);
    for (genvar b = 0; b < 2; b++) begin : g_bit
      assign nxt_tab[s][b] = SW'(fallback(16'(PATTERN), PAT_W, K, 1'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SW'(S_0);
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.in_valid) state_nxt = nxt_tab[state][bus.in];
  end

  always_comb begin
    bus.progress = prog_tab[state];
    bus.match    = (prog_tab[state] == S_MATCH);
  end

  assign enter_match = bus.in_valid && (state_nxt == S_MATCH);

`ifdef PATTERN_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  pattern_detect_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (enter_match),
    .cnt   (cnt_q)
  );

  assign bus.match_cnt = cnt_q;
`else
  wire unused_cnt = &{1'b0, bus.cnt_clr, enter_match};
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// tb/tb_pattern_detect_fsm.sv - four detector configurations checked against a history-window model
module tb_pattern_detect_fsm;

`ifdef PATTERN_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int          PW  [4] = '{4, 4, 4, 1};
  localparam logic [15:0] PAT [4] = '{16'b1011, 16'b1011, 16'b1011, 16'b1};
  localparam bit          OV  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int          CW  [4] = '{8, 8, 2, 8};

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pattern_detect_if #(.PAT_W(4), .CNT_W(8)) if0 ();
  pattern_detect_if #(.PAT_W(4), .CNT_W(8)) if1 ();
  pattern_detect_if #(.PAT_W(4), .CNT_W(2)) if2 ();
  pattern_detect_if #(.PAT_W(1), .CNT_W(8)) if3 ();

  pattern_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    u_ov (.clk(clk), .reset(reset), .bus(if0));
  pattern_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    u_no (.clk(clk), .reset(reset), .bus(if1));
  pattern_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    u_c2 (.clk(clk), .reset(reset), .bus(if2));
  pattern_detect_fsm #(.PAT_W(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(8))
    u_p1 (.clk(clk), .reset(reset), .bus(if3));

  logic [2:0] obs_prog  [4];
  logic       obs_match [4];
  logic [7:0] obs_cnt   [4];

  assign obs_prog[0] = if0.progress;
  assign obs_prog[1] = if1.progress;
  assign obs_prog[2] = if2.progress;
  assign obs_prog[3] = 3'(if3.progress);
  assign obs_match[0] = if0.match;
  assign obs_match[1] = if1.match;
  assign obs_match[2] = if2.match;
  assign obs_match[3] = if3.match;
  assign obs_cnt[0] = if0.match_cnt;
  assign obs_cnt[1] = if1.match_cnt;
  assign obs_cnt[2] = 8'(if2.match_cnt);
  assign obs_cnt[3] = if3.match_cnt;

  // Model: accepted bits since reset (newest in bit 0); progress is the longest recent
  // window equal to a pattern prefix. Without overlap the window restarts after a match.
  logic [31:0] m_hist [4];
  int          m_len  [4];
  int          m_prog [4];
  int          m_cnt  [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit v, input bit b, input bit c);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_hist[i] = '0; m_len[i] = 0; m_prog[i] = 0; m_cnt[i] = 0;
      end else begin
        bit hit;
        hit = 1'b0;
        if (v) begin
          int best;
          if (!OV[i] && m_prog[i] == PW[i]) m_len[i] = 0;
          m_hist[i] = {m_hist[i][30:0], b};
          if (m_len[i] < 31) m_len[i]++;
          best = 0;
          for (int l = 1; l <= PW[i]; l++)
            if (l <= m_len[i] && ((m_hist[i] & ((32'd1 << l) - 1)) == 32'(PAT[i] >> (PW[i] - l))))
              best = l;
          m_prog[i] = best;
          hit = (best == PW[i]);
        end
        if (c) m_cnt[i] = 0;
        else if (hit && m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
        if (!CNT_EN) m_cnt[i] = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit b, input bit c);
    @(negedge clk);
    reset = r;
    if0.in_valid = v; if0.in = b; if0.cnt_clr = c;
    if1.in_valid = v; if1.in = b; if1.cnt_clr = c;
    if2.in_valid = v; if2.in = b; if2.cnt_clr = c;
    if3.in_valid = v; if3.in = b; if3.cnt_clr = c;
    @(posedge clk);
    #1;
    model_step(r, v, b, c);
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_prog[i] !== 3'd0 || obs_match[i] !== 1'b0 || obs_cnt[i] !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset[%0d] got prog=%0d match=%0b cnt=%0d want 0/0/0",
                 i, obs_prog[i], obs_match[i], obs_cnt[i]);
      end
    end
  endtask

  task automatic test_stream;
    bit stream [7] = '{1, 0, 1, 1, 0, 1, 1};
    bit ov_m   [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit no_m   [7] = '{0, 0, 0, 1, 0, 0, 0};
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 7; n++) begin
      cyc(0, 1, stream[n], 0);
      tests_run++;
      if (obs_match[0] !== ov_m[n] || obs_match[1] !== no_m[n]) begin
        tests_failed++;
        $display("FAIL stream_match bit%0d got ov=%0b no=%0b want ov=%0b no=%0b",
                 n + 1, obs_match[0], obs_match[1], ov_m[n], no_m[n]);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (obs_prog[i] !== 3'(m_prog[i]) || obs_cnt[i] !== 8'(m_cnt[i])) begin
          tests_failed++;
          $display("FAIL stream_model[%0d] bit%0d got prog=%0d cnt=%0d want prog=%0d cnt=%0d",
                   i, n + 1, obs_prog[i], obs_cnt[i], m_prog[i], m_cnt[i]);
        end
      end
    end
    tests_run++;
    if (obs_cnt[0] !== (CNT_EN ? 8'd2 : 8'd0) || obs_cnt[1] !== (CNT_EN ? 8'd1 : 8'd0)) begin
      tests_failed++;
      $display("FAIL stream_cnt got ov=%0d no=%0d want ov=%0d no=%0d",
               obs_cnt[0], obs_cnt[1], CNT_EN ? 2 : 0, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_gap;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    for (int n = 0; n < 5; n++) begin
      cyc(0, 0, n[0], 0);
      tests_run++;
      if (obs_prog[0] !== 3'd2 || obs_match[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_hold cyc%0d got prog=%0d match=%0b want 2/0", n, obs_prog[0], obs_match[0]);
      end
    end
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    tests_run++;
    if (obs_match[0] !== 1'b1 || obs_cnt[0] !== (CNT_EN ? 8'd1 : 8'd0)) begin
      tests_failed++;
      $display("FAIL gap_match got match=%0b cnt=%0d want 1/%0d", obs_match[0], obs_cnt[0], CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    tests_run++;
    if (obs_prog[0] !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_prog got %0d want 0", obs_prog[0]);
    end
    cyc(0, 1, 1, 0);
    tests_run++;
    if (obs_prog[0] !== 3'd1 || obs_match[0] !== 1'b0 || obs_cnt[0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_after got prog=%0d match=%0b cnt=%0d want 1/0/0",
               obs_prog[0], obs_match[0], obs_cnt[0]);
    end
  endtask

  task automatic test_saturate;
    bit pat [4] = '{1, 0, 1, 1};
    int want [5] = '{1, 2, 3, 3, 3};
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4; n++) cyc(0, 1, pat[n], 0);
      tests_run++;
      if (obs_match[2] !== 1'b1 || obs_cnt[2] !== (CNT_EN ? 8'(want[k]) : 8'd0)) begin
        tests_failed++;
        $display("FAIL sat_cnt match%0d got match=%0b cnt=%0d want 1/%0d",
                 k + 1, obs_match[2], obs_cnt[2], CNT_EN ? want[k] : 0);
      end
    end
    for (int n = 0; n < 4; n++) cyc(0, 1, pat[n], n == 3);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_match[i] !== 1'b1 || obs_cnt[i] !== 8'd0) begin
        tests_failed++;
        $display("FAIL clr_priority[%0d] got match=%0b cnt=%0d want 1/0", i, obs_match[i], obs_cnt[i]);
      end
    end
  endtask

  task automatic test_single_bit;
    cyc(1, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      cyc(0, 1, 1, 0);
      tests_run++;
      if (obs_match[3] !== 1'b1 || obs_prog[3] !== 3'd1 || obs_cnt[3] !== (CNT_EN ? 8'(n) : 8'd0)) begin
        tests_failed++;
        $display("FAIL pw1 bit%0d got match=%0b prog=%0d cnt=%0d want 1/1/%0d",
                 n, obs_match[3], obs_prog[3], obs_cnt[3], CNT_EN ? n : 0);
      end
    end
  endtask

  task automatic test_random;
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit r, v, b, c;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 29) == 0);
      cyc(r, v, b, c);
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (obs_prog[i] !== 3'(m_prog[i]) || obs_match[i] !== (m_prog[i] == PW[i]) ||
            obs_cnt[i] !== 8'(m_cnt[i])) begin
          tests_failed++;
          $display("FAIL random[%0d] cyc%0d got prog=%0d match=%0b cnt=%0d want prog=%0d match=%0b cnt=%0d",
                   i, n, obs_prog[i], obs_match[i], obs_cnt[i],
                   m_prog[i], m_prog[i] == PW[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    if0.in_valid = 0; if0.in = 0; if0.cnt_clr = 0;
    if1.in_valid = 0; if1.in = 0; if1.cnt_clr = 0;
    if2.in_valid = 0; if2.in = 0; if2.cnt_clr = 0;
    if3.in_valid = 0; if3.in = 0; if3.cnt_clr = 0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0; m_len[i] = 0; m_prog[i] = 0; m_cnt[i] = 0;
    end
    test_reset();
    test_stream();
    test_gap();
    test_reset_mid();
    test_saturate();
    test_single_bit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_detect_fsm.md
PATTERN_DETECT_FSM -- requirements
Module: pattern_detect_fsm

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (1..16).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, pattern to detect; bit PAT_W-1 is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  qualifies in; a bit is consumed only when in_valid=1.
REQ-008 SHALL have port in  input  1  serial data bit.
REQ-009 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-010 SHALL have port match  output  1  Moore output, 1 while in state S_MATCH.
REQ-011 SHALL have port progress  output  $clog2(PAT_W+1)  number of pattern bits currently matched (state index).
REQ-012 SHALL have port match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-013 SHALL implement states S_0..S_(PAT_W-1) (k bits matched) plus S_MATCH (PAT_W bits matched; progress=PAT_W).
REQ-014 SHALL hold the state, match and progress unchanged in any cycle with in_valid=0.
REQ-015 SHALL advance S_k to S_(k+1) (S_(PAT_W-1) to S_MATCH) when in_valid=1 and in equals pattern bit PAT_W-1-k.
REQ-016 SHALL, on a mismatch with OVERLAP=1, go to the state equal to the longest proper suffix of (matched prefix + in) that is also a pattern prefix, with the fallback table computed at elaboration.
REQ-017 SHALL, from S_MATCH with OVERLAP=1, apply the REQ-016 rule to (full pattern + in).
REQ-018 SHALL, from S_MATCH with OVERLAP=0, transition exactly as from S_0.
REQ-019 SHALL assert match in the cycle after the edge that accepts the last pattern bit, and hold it until the next accepted bit.
REQ-020 SHALL increment match_cnt by 1 on each entry into S_MATCH, including S_MATCH to S_MATCH transitions (e.g. PAT_W=1, or an all-ones pattern with overlap).
REQ-021 SHALL saturate match_cnt at 2^CNT_W-1 with no wrap.
REQ-022 SHALL give priority to cnt_clr over a simultaneous increment, so match_cnt=0 next cycle.
REQ-023 SHALL treat any unreachable state encoding as S_0.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set state=S_0, match=0, progress=0 and match_cnt=0, overriding in_valid and cnt_clr.
REQ-025 SHALL, on reset mid-pattern, discard the partial match; no match is generated from bits accepted before the reset.

Configuration
REQ-026 SHALL, with macro PATTERN_DETECT_CNT_EN defined, implement match_cnt per REQ-020 to REQ-022.
REQ-027 SHALL, without PATTERN_DETECT_CNT_EN, tie match_cnt to constant 0, ignore cnt_clr and synthesise no counter flops; match and progress behaviour are unchanged.

Structure
REQ-028 SHALL place in shared package pattern_detect_pkg: the state-width function, the S_0 encoding constant and the elaboration-time fallback-table function.
REQ-029 SHALL implement the saturating counter as sub-module pattern_detect_cnt, instantiated only under PATTERN_DETECT_CNT_EN.

Verification
REQ-030 SHALL cover: defaults, OVERLAP=1, bits 1,0,1,1,0,1,1 each valid -> match high after the 4th and 7th bits; match_cnt=2.
REQ-031 SHALL cover: same stream, OVERLAP=0 -> match high only after the 4th bit; match_cnt=1.
REQ-032 SHALL cover: bits 1,0 then in_valid=0 for 5 cycles with in toggling, then 1,1 -> progress holds 2 during the gap; one match.
REQ-033 SHALL cover: bits 1,0,1 then reset=1 for one cycle, then 1 -> progress=0 after reset; no match.
REQ-034 SHALL cover: CNT_W=2, 5 matches -> match_cnt sequence 1,2,3,3,3; cnt_clr coincident with a match -> match_cnt=0.
REQ-035 SHALL cover: PAT_W=1, PATTERN=1, OVERLAP=1, in=1 for 3 valid cycles -> match stays high; match_cnt=3.
